// File: rtl/trace_segment_sequencer_if.sv
// Sample-stream and line-drawer segment handshake seen by the trace sequencer.
// master = sequencer side, slave = capture logic / line drawer side.
interface trace_segment_sequencer_if #(
   parameter int SAMPLE_W = 8
);
   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample_data;
   logic                sample_ready;
   logic                seg_start;
   logic [9:0]          seg_x0;
   logic [9:0]          seg_y0;
   logic [9:0]          seg_x1;
   logic [9:0]          seg_y1;
   logic                seg_done;

   modport master (
      input  sample_valid, sample_data, seg_done,
      output sample_ready, seg_start, seg_x0, seg_y0, seg_x1, seg_y1
   );

   modport slave (
      output sample_valid, sample_data, seg_done,
      input  sample_ready, seg_start, seg_x0, seg_y0, seg_x1, seg_y1
   );
endinterface

// File: rtl/trace_segment_sequencer.sv
// Turns an ADC sample stream into one line segment per sample pair across a
// horizontal sweep, driving the line drawer through a start/done handshake.
module trace_segment_sequencer #(
   parameter int SAMPLE_W     = 8,
   parameter int H_ACTIVE     = 640,
   parameter int X_STEP       = 1,
   parameter int Y_BASE       = 112,
   parameter int DONE_TIMEOUT = 1023
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      i_arm,
   trace_segment_sequencer_if.master io_seg,
   output logic                      o_busy,
   output logic                      o_sweep_done,
   output logic                      o_timeout_err,
   output logic [15:0]               o_sweep_count
);
   localparam logic [9:0]  Y_TOP    = 10'(Y_BASE + (1 << SAMPLE_W) - 1);
   localparam logic [10:0] X_LAST   = 11'(H_ACTIVE - 1);
   localparam logic [10:0] X_INC    = 11'(X_STEP);
   localparam logic [15:0] TMO_LAST = 16'(DONE_TIMEOUT - 1);
   localparam bit          TMO_EN   = (DONE_TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IDLE, S_FIRST, S_WAIT_SAMPLE, S_ISSUE, S_WAIT_DONE, S_SWEEP_END
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_x_prev, r_y_prev, w_x_nxt, w_y_nxt;
   logic [9:0]  r_x0, r_y0, r_x1, r_y1;
   logic [9:0]  w_x0_nxt, w_y0_nxt, w_x1_nxt, w_y1_nxt;
   logic [15:0] r_timer, w_timer_nxt;
   logic [15:0] r_count;
   logic        r_ready, r_start, r_busy, r_sweep_done, r_terr, w_terr_nxt;
   logic        w_xfer, w_at_end, w_at_end_nxt;
   logic [9:0]  w_y_new;

   assign w_xfer       = io_seg.sample_valid & r_ready;
   assign w_y_new      = Y_TOP - 10'(io_seg.sample_data);
   assign w_at_end     = ({1'b0, r_x_prev} + X_INC) > X_LAST;
   assign w_at_end_nxt = ({1'b0, w_x_nxt} + X_INC) > X_LAST;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x_prev;
      w_y_nxt     = r_y_prev;
      w_x0_nxt    = r_x0;
      w_y0_nxt    = r_y0;
      w_x1_nxt    = r_x1;
      w_y1_nxt    = r_y1;
      w_timer_nxt = r_timer;
      w_terr_nxt  = r_terr;
      case (r_state)
         S_IDLE: if (i_arm) begin
            w_state_nxt = S_FIRST;
            w_terr_nxt  = 1'b0;
            w_x_nxt     = '0;
         end
         S_FIRST: if (w_xfer) begin
            w_y_nxt     = w_y_new;
            w_state_nxt = S_WAIT_SAMPLE;
         end
         S_WAIT_SAMPLE: begin
            if (w_at_end) w_state_nxt = S_SWEEP_END;
            else if (w_xfer) begin
               w_x0_nxt    = r_x_prev;
               w_y0_nxt    = r_y_prev;
               w_x1_nxt    = 10'({1'b0, r_x_prev} + X_INC);
               w_y1_nxt    = w_y_new;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_timer_nxt = '0;
            w_state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // seg_done wins over a timeout expiring in the same cycle
            if (io_seg.seg_done) begin
               w_x_nxt     = r_x1;
               w_y_nxt     = r_y1;
               w_state_nxt = S_WAIT_SAMPLE;
            end else if (TMO_EN && r_timer == TMO_LAST) begin
               w_terr_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer + 16'd1;
            end
         end
         S_SWEEP_END: w_state_nxt = S_IDLE;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered off the next state so they line up with r_state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x_prev     <= '0;
         r_y_prev     <= '0;
         r_x0         <= '0;
         r_y0         <= '0;
         r_x1         <= '0;
         r_y1         <= '0;
         r_timer      <= '0;
         r_terr       <= 1'b0;
         r_ready      <= 1'b0;
         r_start      <= 1'b0;
         r_busy       <= 1'b0;
         r_sweep_done <= 1'b0;
         r_count      <= '0;
      end else begin
         r_x_prev     <= w_x_nxt;
         r_y_prev     <= w_y_nxt;
         r_x0         <= w_x0_nxt;
         r_y0         <= w_y0_nxt;
         r_x1         <= w_x1_nxt;
         r_y1         <= w_y1_nxt;
         r_timer      <= w_timer_nxt;
         r_terr       <= w_terr_nxt;
         r_ready      <= (w_state_nxt == S_FIRST) ||
                         (w_state_nxt == S_WAIT_SAMPLE && !w_at_end_nxt);
         r_start      <= (w_state_nxt == S_ISSUE);
         r_busy       <= (w_state_nxt != S_IDLE);
         r_sweep_done <= (w_state_nxt == S_SWEEP_END);
         if (w_state_nxt == S_SWEEP_END) r_count <= r_count + 16'd1;
      end
   end

   assign io_seg.sample_ready = r_ready;
   assign io_seg.seg_start    = r_start;
   assign io_seg.seg_x0       = r_x0;
   assign io_seg.seg_y0       = r_y0;
   assign io_seg.seg_x1       = r_x1;
   assign io_seg.seg_y1       = r_y1;
   assign o_busy              = r_busy;
   assign o_sweep_done        = r_sweep_done;
   assign o_timeout_err       = r_terr;
   assign o_sweep_count       = r_count;
endmodule

// File: tb/tb_trace_segment_sequencer.sv
// Bench for trace_segment_sequencer: three configurations (default, X_STEP=4,
// DONE_TIMEOUT=16) sharing clock and reset, scoreboarded segment checks.
module tb_trace_segment_sequencer;
   typedef struct packed { logic [9:0] x0, y0, x1, y1; } seg_t;
   typedef struct packed {
      logic vld, rdy, st, dn, busy, swd, terr;
      logic [7:0] dat; logic [15:0] cnt; seg_t seg;
   } obs_t;

   localparam logic [9:0] YT = 10'd367;   // Y_BASE + 255

   logic        clk = 1'b0;
   logic        reset_n;
   logic        arm  [3];
   logic        busy [3], swd [3], terr [3];
   logic [15:0] scnt [3];
   int          checks = 0, fails = 0, cyc = 0;
   seg_t        sq0[$], sq1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   trace_segment_sequencer_if ia (), ib (), ic ();

   trace_segment_sequencer u_a (
      .clk(clk), .reset_n(reset_n), .i_arm(arm[0]), .io_seg(ia),
      .o_busy(busy[0]), .o_sweep_done(swd[0]), .o_timeout_err(terr[0]), .o_sweep_count(scnt[0]));
   trace_segment_sequencer #(.X_STEP(4)) u_b (
      .clk(clk), .reset_n(reset_n), .i_arm(arm[1]), .io_seg(ib),
      .o_busy(busy[1]), .o_sweep_done(swd[1]), .o_timeout_err(terr[1]), .o_sweep_count(scnt[1]));
   trace_segment_sequencer #(.DONE_TIMEOUT(16)) u_c (
      .clk(clk), .reset_n(reset_n), .i_arm(arm[2]), .io_seg(ic),
      .o_busy(busy[2]), .o_sweep_done(swd[2]), .o_timeout_err(terr[2]), .o_sweep_count(scnt[2]));

   function automatic logic [9:0] ymap(input logic [7:0] d);
      return YT - {2'b00, d};
   endfunction

   task automatic sense(input int k, output obs_t o);
      o = '0;
      case (k)
         0: begin o.vld = ia.sample_valid; o.rdy = ia.sample_ready; o.st = ia.seg_start; o.dn = ia.seg_done;
                  o.dat = ia.sample_data; o.seg = {ia.seg_x0, ia.seg_y0, ia.seg_x1, ia.seg_y1}; end
         1: begin o.vld = ib.sample_valid; o.rdy = ib.sample_ready; o.st = ib.seg_start; o.dn = ib.seg_done;
                  o.dat = ib.sample_data; o.seg = {ib.seg_x0, ib.seg_y0, ib.seg_x1, ib.seg_y1}; end
         default: begin o.vld = ic.sample_valid; o.rdy = ic.sample_ready; o.st = ic.seg_start; o.dn = ic.seg_done;
                  o.dat = ic.sample_data; o.seg = {ic.seg_x0, ic.seg_y0, ic.seg_x1, ic.seg_y1}; end
      endcase
      o.busy = busy[k]; o.swd = swd[k]; o.terr = terr[k]; o.cnt = scnt[k];
   endtask

   task automatic drive(input int k, input logic v, input logic [7:0] d, input logic dn);
      case (k)
         0:       begin ia.sample_valid = v; ia.sample_data = d; ia.seg_done = dn; end
         1:       begin ib.sample_valid = v; ib.sample_data = d; ib.seg_done = dn; end
         default: begin ic.sample_valid = v; ic.sample_data = d; ic.seg_done = dn; end
      endcase
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic arm_pulse(input int k);
      tick; arm[k] = 1'b1;
      tick; arm[k] = 1'b0;
   endtask

   // Offer one sample and hold it until it is taken; xc = cycle it was seen accepted.
   task automatic send(input int k, input logic [7:0] d, output int xc);
      obs_t o;
      xc = -1;
      drive(k, 1'b1, d, 1'b0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); sense(k, o);
         if (o.vld && o.rdy) begin xc = cyc; break; end
      end
      tick; drive(k, 1'b0, d, 1'b0);
      checks++;
      if (xc < 0) begin fails++; $display("FAIL send_accept dut%0d sample %h never accepted, want accepted", k, d); end
   endtask

   task automatic wait_start(input int k, output int sc, output obs_t o);
      sc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); sense(k, o);
         if (o.st) begin sc = cyc; break; end
      end
   endtask

   task automatic test_reset;
      obs_t o;
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin arm[k] = 1'b0; drive(k, 1'b0, 8'h00, 1'b0); end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sense(k, o); checks++;
         if ({o.rdy, o.st, o.busy, o.swd, o.terr, o.cnt, o.seg} !== '0) begin
            fails++; $display("FAIL reset_outputs dut%0d got %h want 0", k, {o.rdy, o.st, o.busy, o.swd, o.terr, o.cnt, o.seg});
         end
      end
      tick; reset_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         sense(k, o); checks++;
         if (o.busy !== 1'b0 || o.rdy !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset dut%0d busy=%b rdy=%b want 0 0", k, o.busy, o.rdy);
         end
      end
   endtask

   task automatic test_first_segment;
      obs_t o; int xc, sc;
      arm_pulse(0);
      send(0, 8'd255, xc);
      send(0, 8'd0, xc);
      wait_start(0, sc, o);
      checks++;
      if (sc != xc + 1) begin fails++; $display("FAIL start_latency got cycle %0d want %0d", sc, xc + 1); end
      checks++;
      if (o.seg !== {10'd0, 10'd112, 10'd1, 10'd367}) begin
         fails++; $display("FAIL first_segment got %h want %h", o.seg, {10'd0, 10'd112, 10'd1, 10'd367});
      end
      @(negedge clk); sense(0, o); checks++;
      if (o.st !== 1'b0) begin fails++; $display("FAIL start_pulse_width seg_start=%b want 0", o.st); end
   endtask

   task automatic test_backpressure_and_arm;
      obs_t o;
      seg_t held = {10'd0, 10'd112, 10'd1, 10'd367};
      drive(0, 1'b1, 8'h55, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); sense(0, o); checks++;
         if (o.rdy !== 1'b0 || o.seg !== held) begin
            fails++; $display("FAIL bp_hold rdy=%b seg=%h want 0 %h", o.rdy, o.seg, held);
         end
      end
      tick; arm[0] = 1'b1;
      tick; arm[0] = 1'b0;
      repeat (2) @(negedge clk);
      sense(0, o); checks++;
      if (o.busy !== 1'b1 || o.st !== 1'b0 || o.rdy !== 1'b0 || o.seg !== held) begin
         fails++; $display("FAIL arm_ignored busy=%b st=%b rdy=%b seg=%h want 1 0 0 %h", o.busy, o.st, o.rdy, o.seg, held);
      end
      tick; drive(0, 1'b1, 8'h55, 1'b1);
      tick; drive(0, 1'b1, 8'h55, 1'b0);
      @(negedge clk); sense(0, o); checks++;
      if (o.rdy !== 1'b1) begin fails++; $display("FAIL ready_after_done rdy=%b want 1", o.rdy); end
      tick; drive(0, 1'b0, 8'h00, 1'b0);
      @(negedge clk); sense(0, o); checks++;
      if (o.st !== 1'b1 || o.seg !== {10'd1, 10'd367, 10'd2, ymap(8'h55)}) begin
         fails++; $display("FAIL held_sample_segment st=%b seg=%h want 1 %h", o.st, o.seg, {10'd1, 10'd367, 10'd2, ymap(8'h55)});
      end
   endtask

   task automatic test_reset_midsweep;
      obs_t o;
      tick; #2; reset_n = 1'b0; #1;
      for (int k = 0; k < 3; k++) begin
         sense(k, o); checks++;
         if ({o.rdy, o.st, o.busy, o.swd, o.terr, o.cnt, o.seg} !== '0) begin
            fails++; $display("FAIL async_reset dut%0d got %h want 0", k, {o.rdy, o.st, o.busy, o.swd, o.terr, o.cnt, o.seg});
         end
      end
      tick; tick; reset_n = 1'b1;
   endtask

   task automatic test_timeout;
      obs_t o; int xc, sc; bit sw = 1'b0;
      arm_pulse(2);
      send(2, 8'd10, xc);
      send(2, 8'd20, xc);
      wait_start(2, sc, o);
      checks++;
      if (sc < 0) begin fails++; $display("FAIL tmo_seg_start no seg_start seen, want one"); end
      for (int i = 1; i <= 17; i++) begin
         @(negedge clk); sense(2, o);
         if (o.swd) sw = 1'b1;
         if (i == 16) begin
            checks++;
            if (o.terr !== 1'b0 || o.busy !== 1'b1) begin fails++; $display("FAIL tmo_early terr=%b busy=%b want 0 1", o.terr, o.busy); end
         end
         if (i == 17) begin
            checks++;
            if (o.terr !== 1'b1 || o.busy !== 1'b0) begin fails++; $display("FAIL tmo_set terr=%b busy=%b want 1 0", o.terr, o.busy); end
         end
      end
      checks++;
      if (sw || o.cnt !== 16'd0) begin fails++; $display("FAIL tmo_no_sweep sweep_done_seen=%b count=%0d want 0 0", sw, o.cnt); end
      tick; arm[2] = 1'b1;
      tick; arm[2] = 1'b0;
      @(negedge clk); sense(2, o); checks++;
      if (o.terr !== 1'b0 || o.busy !== 1'b1) begin fails++; $display("FAIL arm_clears_tmo terr=%b busy=%b want 0 1", o.terr, o.busy); end
   endtask

   // Full sweeps on the X_STEP=1 and X_STEP=4 instances in lockstep, continuous
   // samples, drawer answering seg_done 3 cycles after each seg_start.
   task automatic test_sweep;
      obs_t o; seg_t e; seg_t snap [2];
      int acc [2] = '{0, 0}, nseg [2] = '{0, 0}, nswd [2] = '{0, 0}, bp [2] = '{0, 0};
      int dcnt [2] = '{0, 0}, due [2] = '{0, 0};
      int step [2] = '{1, 4}, exp_acc [2] = '{640, 160}, exp_seg [2] = '{639, 159};
      logic [9:0] exp_x1 [2] = '{10'd639, 10'd636};
      logic [9:0] xe [2], ye [2], lastx1 [2], yn;
      logic [7:0] dat [2];
      bit first [2], pend [2] = '{1'b0, 1'b0}, took [2], fin, tout = 1'b1;
      for (int k = 0; k < 2; k++) begin dat[k] = 8'($urandom); drive(k, 1'b1, dat[k], 1'b0); lastx1[k] = '0; end
      tick; arm[0] = 1'b1; arm[1] = 1'b1;
      first = '{1'b1, 1'b1}; xe = '{10'd0, 10'd0}; ye = '{10'd0, 10'd0};
      tick; arm[0] = 1'b0; arm[1] = 1'b0;
      for (int c = 0; c < 8000; c++) begin
         @(negedge clk);
         fin = 1'b1;
         for (int k = 0; k < 2; k++) begin
            sense(k, o);
            took[k] = o.vld && o.rdy;
            if (took[k]) begin
               acc[k]++; yn = ymap(o.dat);
               if (first[k]) first[k] = 1'b0;
               else begin
                  e = {xe[k], ye[k], 10'(xe[k] + step[k]), yn};
                  if (k == 0) sq0.push_back(e); else sq1.push_back(e);
                  xe[k] = 10'(xe[k] + step[k]); due[k] = cyc + 1;
               end
               ye[k] = yn;
            end
            if (o.st) begin
               nseg[k]++; lastx1[k] = o.seg.x1; snap[k] = o.seg; pend[k] = 1'b1; dcnt[k] = 3;
               if (k == 0 && sq0.size() > 0) e = sq0.pop_front();
               else if (k == 1 && sq1.size() > 0) e = sq1.pop_front();
               else e = 'x;
               checks++;
               if (o.seg !== e || cyc != due[k]) begin
                  fails++; $display("FAIL sweep_segment dut%0d got %h at cycle %0d want %h at cycle %0d", k, o.seg, cyc, e, due[k]);
               end
            end else if (pend[k] && (o.rdy || o.seg !== snap[k])) bp[k]++;
            if (o.dn) pend[k] = 1'b0;
            if (o.swd) nswd[k]++;
            if (!(nswd[k] > 0 && !o.busy)) fin = 1'b0;
         end
         if (fin) begin tout = 1'b0; break; end
         tick;
         for (int k = 0; k < 2; k++) begin
            if (took[k]) dat[k] = 8'($urandom);
            drive(k, 1'b1, dat[k], dcnt[k] == 1);
            if (dcnt[k] > 0) dcnt[k]--;
         end
      end
      for (int k = 0; k < 2; k++) drive(k, 1'b0, 8'h00, 1'b0);
      checks++;
      if (tout) begin fails++; $display("FAIL sweep_timeout sweeps still busy after 8000 cycles, want done"); end
      for (int k = 0; k < 2; k++) begin
         sense(k, o);
         checks++;
         if (acc[k] != exp_acc[k]) begin fails++; $display("FAIL sweep_samples dut%0d got %0d want %0d", k, acc[k], exp_acc[k]); end
         checks++;
         if (nseg[k] != exp_seg[k]) begin fails++; $display("FAIL sweep_segments dut%0d got %0d want %0d", k, nseg[k], exp_seg[k]); end
         checks++;
         if (lastx1[k] !== exp_x1[k]) begin fails++; $display("FAIL sweep_last_x1 dut%0d got %0d want %0d", k, lastx1[k], exp_x1[k]); end
         checks++;
         if (nswd[k] != 1 || o.cnt !== 16'd1 || o.busy !== 1'b0) begin
            fails++; $display("FAIL sweep_end dut%0d done_pulses=%0d count=%0d busy=%b want 1 1 0", k, nswd[k], o.cnt, o.busy);
         end
         checks++;
         if (bp[k] != 0) begin fails++; $display("FAIL sweep_backpressure dut%0d got %0d violations want 0", k, bp[k]); end
      end
      checks++;
      if (sq0.size() != 0 || sq1.size() != 0) begin
         fails++; $display("FAIL sweep_leftover got %0d/%0d expected segments never issued want 0/0", sq0.size(), sq1.size());
      end
   endtask

   initial begin
      test_reset;
      test_first_segment;
      test_backpressure_and_arm;
      test_reset_midsweep;
      test_timeout;
      test_sweep;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/trace_segment_sequencer.md
Name: trace_segment_sequencer

Overview:
- Initiator side of the line-drawer start/done segment handshake.
- Consumes a stream of ADC samples and converts each sample to a screen Y coordinate.
- Issues one line segment per sample pair, from (x_prev, y_prev) to (x_prev+X_STEP, y_new), and advances X across one horizontal sweep.
- Sits between the sample capture/trigger logic and the line drawer that plots into the framebuffer.

Parameters:
- SAMPLE_W, 8, sample width in bits.
- H_ACTIVE, 640, screen width in pixels; valid X is 0..H_ACTIVE-1.
- X_STEP, 1, X pixels advanced per sample (≥1).
- Y_BASE, 112, Y of the full-scale sample; y = Y_BASE + (2^SAMPLE_W-1 - sample).
- DONE_TIMEOUT, 1023, maximum cycles to wait for seg_done; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- arm  in  1  single-cycle request to begin a sweep.
- sample_valid  in  1  sample available.
- sample_data  in  SAMPLE_W  sample value; 0 = bottom, max = top.
- sample_ready  out  1  sequencer accepts the sample this cycle.
- seg_start  out  1  one-cycle pulse that launches a segment.
- seg_x0, seg_y0, seg_x1, seg_y1  out  10 each  segment endpoints.
- seg_done  in  1  one-cycle pulse from the line drawer.
- busy  out  1  high in any state other than IDLE.
- sweep_done  out  1  one-cycle pulse at normal sweep completion.
- timeout_err  out  1  sticky; set on seg_done timeout.
- sweep_count  out  16  completed sweeps; wraps at 65535→0.

Behaviour:
- Reset: state=IDLE, all outputs 0, internal x_prev/y_prev/timer = 0.
- Sample transfer occurs when sample_valid && sample_ready.
- sample_ready is a registered decode of state and is high only in FIRST and WAIT_SAMPLE.
- Y mapping: y_new = Y_BASE + (2^SAMPLE_W-1 - sample_data).
  - Computed in 10-bit arithmetic.
  - Y_BASE must be chosen so that y_new ≤ 1023; no clamping.
- State IDLE:
  - arm → FIRST; clear timeout_err; x_prev=0.
  - arm is ignored in every other state.
- State FIRST:
  - On transfer, latch y_prev=y_new and go to WAIT_SAMPLE.
  - No segment is issued for the first sample.
- State WAIT_SAMPLE:
  - If x_prev + X_STEP > H_ACTIVE-1: go to SWEEP_END without accepting a sample (sample_ready low that cycle).
  - Else, on transfer: load seg_x0=x_prev, seg_y0=y_prev, seg_x1=x_prev+X_STEP, seg_y1=y_new; go to ISSUE.
- State ISSUE:
  - seg_start=1 for exactly this one cycle.
  - Clear timer; go to WAIT_DONE.
- State WAIT_DONE:
  - seg_x*/seg_y* are held stable from ISSUE until seg_done is seen.
  - On seg_done: x_prev=seg_x1, y_prev=seg_y1; go to WAIT_SAMPLE.
  - Else timer increments. When DONE_TIMEOUT≠0 and timer==DONE_TIMEOUT-1 with no seg_done: set timeout_err, go to IDLE (sweep_done not pulsed, sweep_count unchanged).
  - seg_done arriving in the same cycle as the timeout expiry takes priority as a normal completion.
- State SWEEP_END:
  - sweep_done=1 for one cycle; sweep_count+1; go to IDLE.
- seg_done received outside WAIT_DONE is ignored.
- Segments per sweep = floor((H_ACTIVE-1)/X_STEP); samples accepted per sweep = that count + 1.
- Latency:
  - Accepting transfer to seg_start = 1 cycle.
  - seg_done to the next sample_ready = 1 cycle.
- Reset asserted mid-sweep: immediate return to IDLE with all outputs 0; the line drawer is reset by the same reset_n.

Test Plan:
- Defaults; arm, samples 255 then 0 → one seg_start with x0=0, y0=112, x1=1, y1=367; seg_start exactly one cycle after the second transfer.
- Full sweep, bench drawer returns seg_done 3 cycles after seg_start, continuous samples → 640 samples accepted, 639 seg_start pulses, final x1=639, one sweep_done, sweep_count=1, busy then falls.
- Backpressure: sample_valid held high during WAIT_DONE → sample_ready stays 0 and no sample is lost; seg_x*/seg_y* remain stable until seg_done.
- X_STEP=4 → 159 segments per sweep, final x1=636, sweep ends without accepting a 161st sample.
- DONE_TIMEOUT=16, seg_done withheld → timeout_err=1 after 16 cycles in WAIT_DONE; state IDLE; no sweep_done; next arm clears timeout_err.
- arm pulsed while busy → ignored; reset_n pulled low in WAIT_DONE → all outputs 0 immediately; a fresh arm starts a new sweep at x=0.
